// File: rtl/ysyx_23060077_wbu_arb.sv
// Write-back arbiter: one single-entry buffer per requester (EXU/LSU/CSR),
// round-robin grant of one buffered result per cycle into the register file.
module ysyx_23060077_wbu_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exu_valid,
  input  logic                  lsu_valid,
  input  logic                  csr_valid,
  output logic                  exu_ready,
  output logic                  lsu_ready,
  output logic                  csr_ready,
  input  logic [REG_WIDTH-1:0]  exu_rd_addr,
  input  logic [REG_WIDTH-1:0]  lsu_rd_addr,
  input  logic [REG_WIDTH-1:0]  csr_rd_addr,
  input  logic [DATA_WIDTH-1:0] exu_rd_data,
  input  logic [DATA_WIDTH-1:0] lsu_rd_data,
  input  logic [DATA_WIDTH-1:0] csr_rd_data,
  output logic                  reg_rd_en,
  output logic [REG_WIDTH-1:0]  reg_rd_addr,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  wb_busy,
  output logic                  wb_conflict
);

  localparam int unsigned N_REQ = 3;
  localparam int unsigned PTR_W = 2;

  // Modulo-3 pointer addition; operands are always in 0..2.
  function automatic logic [PTR_W-1:0] idx_add(input logic [PTR_W-1:0] a,
                                               input logic [PTR_W-1:0] b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PTR_W+1)'(N_REQ)) s = s - (PTR_W+1)'(N_REQ);
    return s[PTR_W-1:0];
  endfunction

  logic [N_REQ-1:0]      valid;
  logic [N_REQ-1:0]      ready;
  logic [N_REQ-1:0]      gnt;
  logic                  any_gnt;
  logic [PTR_W-1:0]      win;
  logic [REG_WIDTH-1:0]  in_addr [N_REQ];
  logic [DATA_WIDTH-1:0] in_data [N_REQ];

  logic [N_REQ-1:0]      full_q, full_d;
  logic [REG_WIDTH-1:0]  addr_q [N_REQ];
  logic [REG_WIDTH-1:0]  addr_d [N_REQ];
  logic [DATA_WIDTH-1:0] data_q [N_REQ];
  logic [DATA_WIDTH-1:0] data_d [N_REQ];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  rd_en_q, rd_en_d;
  logic [REG_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  conflict_q, conflict_d;

  assign valid      = {csr_valid, lsu_valid, exu_valid};
  assign in_addr[0] = exu_rd_addr;
  assign in_addr[1] = lsu_rd_addr;
  assign in_addr[2] = csr_rd_addr;
  assign in_data[0] = exu_rd_data;
  assign in_data[1] = lsu_rd_data;
  assign in_data[2] = csr_rd_data;

  // Round-robin pick among full buffers, starting at rr_ptr_q.
  always_comb begin
    logic [PTR_W-1:0] idx;
    any_gnt = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = idx_add(rr_ptr_q, PTR_W'(k));
      if (!any_gnt && full_q[idx]) begin
        any_gnt = 1'b1;
        win     = idx;
      end
    end
    gnt = any_gnt ? (N_REQ'(1) << win) : '0;
  end

  // Ready depends only on state, never on any valid input.
  assign ready     = ~full_q | gnt;
  assign exu_ready = ready[0];
  assign lsu_ready = ready[1];
  assign csr_ready = ready[2];
  assign wb_busy   = |full_q;

  always_comb begin
    full_d     = full_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rr_ptr_d   = rr_ptr_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    conflict_d = conflict_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (valid[i] && ready[i]) begin
        full_d[i] = 1'b1;
        addr_d[i] = in_addr[i];
        data_d[i] = in_data[i];
      end else if (gnt[i]) begin
        full_d[i] = 1'b0;
      end
    end
    // Writes to x0 are consumed but never reach the register file.
    if (any_gnt) begin
      rr_ptr_d  = idx_add(win, PTR_W'(1));
      rd_en_d   = |addr_q[win];
      rd_addr_d = addr_q[win];
      rd_data_d = data_q[win];
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      for (int j = i + 1; j < int'(N_REQ); j++) begin
        if (full_d[i] && full_d[j] && (addr_d[i] == addr_d[j]) && (|addr_d[i]))
          conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q     <= '0;
      rr_ptr_q   <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      conflict_q <= conflict_d;
    end
  end

  // Buffer payloads are only meaningful while their full bit is set.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign reg_rd_en   = rd_en_q;
  assign reg_rd_addr = rd_addr_q;
  assign reg_rd_data = rd_data_q;
  assign wb_conflict = conflict_q;

endmodule

// File: tb/tb_ysyx_23060077_wbu_arb.sv
// Directed bench for the write-back arbiter with hand-computed expectations.
module tb_ysyx_23060077_wbu_arb;

  logic        clock, reset;
  logic        exu_valid, lsu_valid, csr_valid;
  logic        exu_ready, lsu_ready, csr_ready;
  logic [4:0]  exu_rd_addr, lsu_rd_addr, csr_rd_addr;
  logic [31:0] exu_rd_data, lsu_rd_data, csr_rd_data;
  logic        reg_rd_en;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        wb_busy, wb_conflict;

  int tests = 0;
  int fails = 0;
  int cnt [3];

  ysyx_23060077_wbu_arb #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .lsu_valid(lsu_valid), .csr_valid(csr_valid),
    .exu_ready(exu_ready), .lsu_ready(lsu_ready), .csr_ready(csr_ready),
    .exu_rd_addr(exu_rd_addr), .lsu_rd_addr(lsu_rd_addr), .csr_rd_addr(csr_rd_addr),
    .exu_rd_data(exu_rd_data), .lsu_rd_data(lsu_rd_data), .csr_rd_data(csr_rd_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .wb_busy(wb_busy), .wb_conflict(wb_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; lsu_valid = 1'b0; csr_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    exu_valid = 1'b1; lsu_valid = 1'b1; csr_valid = 1'b1;
    exu_rd_addr = a0; lsu_rd_addr = a1; csr_rd_addr = a2;
    exu_rd_data = d0; lsu_rd_data = d1; csr_rd_data = d2;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    tick();
    chk({tag, "_en"}, 32'(reg_rd_en), 32'd1);
    chk({tag, "_addr"}, 32'(reg_rd_addr), 32'(a));
    chk({tag, "_data"}, reg_rd_data, d);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    exu_rd_addr = '0; lsu_rd_addr = '0; csr_rd_addr = '0;
    exu_rd_data = '0; lsu_rd_data = '0; csr_rd_data = '0;

    // Reset values
    tick();
    tick();
    chk("rst_en", 32'(reg_rd_en), 32'd0);
    chk("rst_addr", 32'(reg_rd_addr), 32'd0);
    chk("rst_data", reg_rd_data, 32'd0);
    chk("rst_busy", 32'(wb_busy), 32'd0);
    chk("rst_conflict", 32'(wb_conflict), 32'd0);
    reset = 1'b0;
    chk("rst_ready", 32'({exu_ready, lsu_ready, csr_ready}), 32'h7);

    // Single EXU write
    exu_valid = 1'b1; exu_rd_addr = 5'd5; exu_rd_data = 32'h1234;
    tick();
    exu_valid = 1'b0;
    chk("single_busy", 32'(wb_busy), 32'd1);
    chk("single_no_early_en", 32'(reg_rd_en), 32'd0);
    expect_wr("single", 5'd5, 32'h1234);
    chk("single_busy_after", 32'(wb_busy), 32'd0);
    tick();
    chk("single_en_drop", 32'(reg_rd_en), 32'd0);
    chk("single_addr_hold", 32'(reg_rd_addr), 32'd5);
    chk("single_data_hold", reg_rd_data, 32'h1234);

    // Simultaneous accept from rr_ptr=0
    do_reset();
    load3(5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3);
    tick();
    idle_inputs();
    chk("all3_busy", 32'(wb_busy), 32'd1);
    chk("all3_ready", 32'({exu_ready, lsu_ready, csr_ready}), 32'h4);
    expect_wr("all3_w1", 5'd1, 32'hA1);
    expect_wr("all3_w2", 5'd2, 32'hA2);
    expect_wr("all3_w3", 5'd3, 32'hA3);
    tick();
    chk("all3_idle_en", 32'(reg_rd_en), 32'd0);
    chk("all3_idle_busy", 32'(wb_busy), 32'd0);
    chk("all3_no_conflict", 32'(wb_conflict), 32'd0);
    // rr_ptr back at 0: EXU must win first again
    load3(5'd4, 5'd5, 5'd6, 32'hB4, 32'hB5, 32'hB6);
    tick();
    idle_inputs();
    expect_wr("rr0_w1", 5'd4, 32'hB4);
    expect_wr("rr0_w2", 5'd5, 32'hB5);
    expect_wr("rr0_w3", 5'd6, 32'hB6);
    tick();

    // LSU writes x0: consumed silently, rr_ptr moves to 2
    lsu_valid = 1'b1; lsu_rd_addr = 5'd0; lsu_rd_data = 32'hDEAD;
    chk("x0_ready_pre", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_ready_full", 32'(lsu_ready), 32'd1);
    chk("x0_no_en1", 32'(reg_rd_en), 32'd0);
    tick();
    chk("x0_no_en2", 32'(reg_rd_en), 32'd0);
    chk("x0_busy", 32'(wb_busy), 32'd0);
    load3(5'd8, 5'd9, 5'd10, 32'hC8, 32'hC9, 32'hCA);
    tick();
    idle_inputs();
    expect_wr("rr2_w1", 5'd10, 32'hCA);
    expect_wr("rr2_w2", 5'd8, 32'hC8);
    expect_wr("rr2_w3", 5'd9, 32'hC9);
    tick();

    // Saturation: 30 back-to-back writes, strict rotation
    do_reset();
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    load3(5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300);
    tick();
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("sat_en", 32'(reg_rd_en), 32'd1);
      chk("sat_addr", 32'(reg_rd_addr), 32'((c % 3) + 1));
      chk("sat_data", reg_rd_data, 32'(((c % 3) + 1) * 32'h100));
      if (reg_rd_en && reg_rd_addr >= 5'd1 && reg_rd_addr <= 5'd3)
        cnt[int'(reg_rd_addr) - 1]++;
    end
    idle_inputs();
    chk("sat_cnt_exu", 32'(cnt[0]), 32'd10);
    chk("sat_cnt_lsu", 32'(cnt[1]), 32'd10);
    chk("sat_cnt_csr", 32'(cnt[2]), 32'd10);

    // Conflict: EXU and CSR both hold rd=7
    do_reset();
    exu_valid = 1'b1; exu_rd_addr = 5'd7; exu_rd_data = 32'h77;
    csr_valid = 1'b1; csr_rd_addr = 5'd7; csr_rd_data = 32'h78;
    tick();
    idle_inputs();
    chk("conf_set", 32'(wb_conflict), 32'd1);
    tick();
    tick();
    tick();
    chk("conf_sticky", 32'(wb_conflict), 32'd1);
    chk("conf_drained", 32'(wb_busy), 32'd0);
    do_reset();
    chk("conf_clear", 32'(wb_conflict), 32'd0);

    // Reset with all three full: nothing stale comes out
    load3(5'd11, 5'd12, 5'd13, 32'hD1, 32'hD2, 32'hD3);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_en", 32'(reg_rd_en), 32'd0);
    chk("midrst_busy", 32'(wb_busy), 32'd0);
    chk("midrst_ready", 32'({exu_ready, lsu_ready, csr_ready}), 32'h7);
    tick();
    chk("midrst_no_stale1", 32'(reg_rd_en), 32'd0);
    tick();
    chk("midrst_no_stale2", 32'(reg_rd_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
